dm_abstract_ctl: RTL and testbench

- Debug Module front-end block, directly upstream of the core's debug control stage.
- Decodes DMI register accesses to dmcontrol, dmstatus, abstractcs, command, abstractauto, data0 and data1.
- Drives the core-side debug handshake: halt_req, resume_req, command, exec.
- Consumes the core's halted, done, write and error responses, and tracks busy, cmderr, resumeack and havereset.

---
 rtl/dm_abstract_ctl_pkg.sv | 56 +++++
 rtl/dm_abstract_ctl_if.sv | 21 ++
 rtl/dm_abstract_ctl_fsm.sv | 76 +++++++
 rtl/dm_abstract_ctl.sv | 187 ++++++++++++++++++
 tb/tb_dm_abstract_ctl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_abstract_ctl_pkg.sv
// Shared debug definitions: DMI register map, field positions, cmderr codes,
// abstract command types and the abstract sequencer state encoding.
package dm_abstract_ctl_pkg;

    // DMI register addresses
    localparam int unsigned AddrData0        = 'h04;
    localparam int unsigned AddrData1        = 'h05;
    localparam int unsigned AddrDmcontrol    = 'h10;
    localparam int unsigned AddrDmstatus     = 'h11;
    localparam int unsigned AddrAbstractcs   = 'h16;
    localparam int unsigned AddrCommand      = 'h17;
    localparam int unsigned AddrAbstractauto = 'h18;

    // dmcontrol fields
    localparam int unsigned DmcHaltreq      = 31;
    localparam int unsigned DmcResumereq    = 30;
    localparam int unsigned DmcAckhavereset = 28;
    localparam int unsigned DmcNdmreset     = 1;
    localparam int unsigned DmcDmactive     = 0;

    // abstractcs fields
    localparam int unsigned AcsCmderrHi = 10;
    localparam int unsigned AcsCmderrLo = 8;

    // dmstatus constant fields
    localparam logic [3:0] DmsVersion = 4'd2;

    // cmderr codes
    localparam logic [2:0] CmdErrNone         = 3'd0;
    localparam logic [2:0] CmdErrBusy         = 3'd1;
    localparam logic [2:0] CmdErrNotSupported = 3'd2;
    localparam logic [2:0] CmdErrException    = 3'd3;
    localparam logic [2:0] CmdErrHaltResume   = 3'd4;
    localparam logic [2:0] CmdErrBus          = 3'd5;

    // Abstract command types (command[31:24])
    localparam logic [7:0] CmdAccessReg   = 8'd0;
    localparam logic [7:0] CmdQuickAccess = 8'd1;
    localparam logic [7:0] CmdAccessMem   = 8'd2;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StExec
    } abs_state_e;

    function automatic logic cmdtype_valid(input logic [7:0] t);
        return (t == CmdAccessReg) || (t == CmdQuickAccess) || (t == CmdAccessMem);
    endfunction

    // Quick-access runs on a running hart; the others need it halted.
    function automatic logic cmdtype_needs_halt(input logic [7:0] t);
        return (t != CmdQuickAccess);
    endfunction

endpackage

// File: rtl/dm_abstract_ctl_if.sv
// DMI access bus between the debug transport and the debug module.
interface dm_abstract_ctl_if #(
    parameter int unsigned ABITS = 7
);
    logic             dmi_req;
    logic             dmi_we;
    logic [ABITS-1:0] dmi_addr;
    logic [31:0]      dmi_wdata;
    logic [31:0]      dmi_rdata;
    logic             dmi_ack;

    modport master (
        output dmi_req, dmi_we, dmi_addr, dmi_wdata,
        input  dmi_rdata, dmi_ack
    );

    modport slave (
        input  dmi_req, dmi_we, dmi_addr, dmi_wdata,
        output dmi_rdata, dmi_ack
    );
endinterface

// File: rtl/dm_abstract_ctl_fsm.sv
// Abstract command sequencer: IDLE -> CHECK -> EXEC -> IDLE, owns cmderr.
module dm_abstract_ctl_fsm
    import dm_abstract_ctl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       abort,
    input  logic       start,
    input  logic [7:0] cmdtype,
    input  logic       halted,
    input  logic       done,
    input  logic       err_haltresume,
    input  logic       err_bus,
    input  logic       err_exception,
    input  logic       busy_err,
    input  logic [2:0] clr_mask,
    output logic       busy,
    output logic       in_exec,
    output logic [2:0] cmderr
);
    abs_state_e state_q, state_d;
    logic [2:0] cmderr_q, cmderr_d;

    // Next state and cmderr; completion/check errors override a busy error
    always_comb begin
        state_d  = state_q;
        cmderr_d = cmderr_q & ~clr_mask;
        if (busy_err && cmderr_q == CmdErrNone) begin
            cmderr_d = CmdErrBusy;
        end
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StCheck;
            end
            StCheck: begin
                state_d = StIdle;
                if (!cmdtype_valid(cmdtype)) begin
                    cmderr_d = CmdErrNotSupported;
                end else if (cmdtype_needs_halt(cmdtype) != halted) begin
                    cmderr_d = CmdErrHaltResume;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (done) begin
                    state_d = StIdle;
                    if (err_haltresume)     cmderr_d = CmdErrHaltResume;
                    else if (err_bus)       cmderr_d = CmdErrBus;
                    else if (err_exception) cmderr_d = CmdErrException;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d  = StIdle;
            cmderr_d = CmdErrNone;
        end
    end

    // State and cmderr registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cmderr_q <= CmdErrNone;
        end else begin
            state_q  <= state_d;
            cmderr_q <= cmderr_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign in_exec = (state_q == StExec);
    assign cmderr  = cmderr_q;

endmodule

// File: rtl/dm_abstract_ctl.sv
// Debug module front-end: DMI register decode, halt/resume handshake and
// abstract command launch towards the core's debug control stage.
module dm_abstract_ctl #(
    parameter int unsigned ABITS     = 7,
    parameter int unsigned DATACOUNT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dm_abstract_ctl_if.slave dmi,
    output logic             ndmreset,
    output logic             halt_req,
    output logic             resume_req,
    output logic [31:0]      command,
    output logic             exec,
    output logic [31:0]      data0_out,
    output logic [31:0]      data1_out,
    input  logic [31:0]      data0_in,
    input  logic [31:0]      data1_in,
    input  logic             halted,
    input  logic             done,
    input  logic             write,
    input  logic             bus,
    input  logic             haltresume,
    input  logic             exception
);
    import dm_abstract_ctl_pkg::*;

    logic        dmactive_q, dmactive_d, haltreq_q, haltreq_d, ndmreset_q, ndmreset_d;
    logic        havereset_q, havereset_d, resume_q, resume_d, resumeack_q, resumeack_d;
    logic [31:0] data0_q, data0_d, data1_q, data1_d, command_q, command_d;
    logic [1:0]  auto_q, auto_d;
    logic        ack_q;
    logic [31:0] rdata_q, rdata_d;

    logic        sel_data0, sel_data1, sel_ctl, sel_status, sel_cs, sel_cmd, sel_auto;
    logic        wr, ctl_wr, data_acc, busy_err, cmd_ok, cmd_wr, auto_hit, start;
    logic        busy, in_exec;
    logic [2:0]  cmderr, clr_mask;
    logic [31:0] wdata, dmstatus, abstractcs, dmcontrol;

    assign wdata      = dmi.dmi_wdata;
    assign sel_data0  = (dmi.dmi_addr == ABITS'(AddrData0));
    assign sel_data1  = (dmi.dmi_addr == ABITS'(AddrData1));
    assign sel_ctl    = (dmi.dmi_addr == ABITS'(AddrDmcontrol));
    assign sel_status = (dmi.dmi_addr == ABITS'(AddrDmstatus));
    assign sel_cs     = (dmi.dmi_addr == ABITS'(AddrAbstractcs));
    assign sel_cmd    = (dmi.dmi_addr == ABITS'(AddrCommand));
    assign sel_auto   = (dmi.dmi_addr == ABITS'(AddrAbstractauto));

    assign wr       = dmi.dmi_req & dmi.dmi_we;
    assign ctl_wr   = wr & sel_ctl;
    // Every other register is held at reset while dmactive is (or becomes) 0
    assign dmactive_d = ctl_wr ? wdata[DmcDmactive] : dmactive_q;
    assign data_acc = dmi.dmi_req & (sel_data0 | sel_data1);
    assign busy_err = busy & ((wr & (sel_cmd | sel_cs | sel_auto)) | data_acc);
    assign cmd_ok   = ~busy & (cmderr == CmdErrNone);
    assign cmd_wr   = wr & sel_cmd & cmd_ok;
    assign auto_hit = dmi.dmi_req & ((sel_data0 & auto_q[0]) | (sel_data1 & auto_q[1]));
    assign start    = cmd_wr | (cmd_ok & auto_hit);
    assign clr_mask = (wr & sel_cs & ~busy) ? wdata[AcsCmderrHi:AcsCmderrLo] : 3'b000;

    dm_abstract_ctl_fsm u_fsm (
        .clk            (clk),
        .rst_n          (rst_n),
        .abort          (~dmactive_d),
        .start          (start),
        .cmdtype        (command_q[31:24]),
        .halted         (halted),
        .done           (done),
        .err_haltresume (haltresume),
        .err_bus        (bus),
        .err_exception  (exception),
        .busy_err       (busy_err),
        .clr_mask       (clr_mask),
        .busy           (busy),
        .in_exec        (in_exec),
        .cmderr         (cmderr)
    );

    assign dmstatus   = {12'd0, {2{havereset_q}}, {2{resumeack_q}}, 4'd0,
                         {2{~halted}}, {2{halted}}, 1'b1, 3'd0, DmsVersion};
    assign abstractcs = {19'd0, busy, 1'b0, cmderr, 4'd0, 4'(DATACOUNT)};
    assign dmcontrol  = {haltreq_q, 29'd0, ndmreset_q, dmactive_q};

    // Next-state of the DM registers and the resume handshake
    always_comb begin
        haltreq_d   = haltreq_q;
        ndmreset_d  = ndmreset_q;
        havereset_d = havereset_q;
        resume_d    = resume_q;
        resumeack_d = resumeack_q;
        data0_d     = data0_q;
        data1_d     = data1_q;
        command_d   = command_q;
        auto_d      = auto_q;
        if (ctl_wr) begin
            haltreq_d  = wdata[DmcHaltreq];
            ndmreset_d = wdata[DmcNdmreset];
            if (wdata[DmcAckhavereset]) havereset_d = 1'b0;
        end
        if (ndmreset_q || (ctl_wr && wdata[DmcNdmreset])) havereset_d = 1'b1;
        if (resume_q && !halted) begin
            resume_d    = 1'b0;
            resumeack_d = 1'b1;
        end
        if (ctl_wr && wdata[DmcResumereq] && !wdata[DmcHaltreq] && !busy) begin
            resume_d    = 1'b1;
            resumeack_d = 1'b0;
        end
        if (busy && write) begin
            data0_d = data0_in;
            data1_d = data1_in;
        end else if (wr && !busy) begin
            if (sel_data0) data0_d = wdata;
            if (sel_data1) data1_d = wdata;
        end
        if (cmd_wr) command_d = wdata;
        if (wr && sel_auto && !busy) auto_d = wdata[1:0];
        if (!dmactive_d) begin
            haltreq_d   = 1'b0;
            ndmreset_d  = 1'b0;
            havereset_d = 1'b1;
            resume_d    = 1'b0;
            resumeack_d = 1'b0;
            data0_d     = '0;
            data1_d     = '0;
            command_d   = '0;
            auto_d      = '0;
        end
    end

    // Read data mux; command is write-only and unmapped addresses read 0
    always_comb begin
        rdata_d = '0;
        if (dmi.dmi_req && !dmi.dmi_we) begin
            if (sel_data0)  rdata_d = data0_q;
            if (sel_data1)  rdata_d = data1_q;
            if (sel_ctl)    rdata_d = dmcontrol;
            if (sel_status) rdata_d = dmstatus;
            if (sel_cs)     rdata_d = abstractcs;
            if (sel_auto)   rdata_d = {30'd0, auto_q};
        end
    end

    // Register file and DMI response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmactive_q  <= 1'b0;
            haltreq_q   <= 1'b0;
            ndmreset_q  <= 1'b0;
            havereset_q <= 1'b1;
            resume_q    <= 1'b0;
            resumeack_q <= 1'b0;
            data0_q     <= '0;
            data1_q     <= '0;
            command_q   <= '0;
            auto_q      <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            dmactive_q  <= dmactive_d;
            haltreq_q   <= haltreq_d;
            ndmreset_q  <= ndmreset_d;
            havereset_q <= havereset_d;
            resume_q    <= resume_d;
            resumeack_q <= resumeack_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            command_q   <= command_d;
            auto_q      <= auto_d;
            ack_q       <= dmi.dmi_req;
            rdata_q     <= rdata_d;
        end
    end

    assign dmi.dmi_ack   = ack_q;
    assign dmi.dmi_rdata = rdata_q;
    assign ndmreset      = ndmreset_q;
    assign halt_req      = haltreq_q & dmactive_q;
    assign resume_req    = resume_q;
    assign command       = command_q;
    // Writing dmactive=0 kills an in-flight command in the same cycle
    assign exec          = in_exec & dmactive_d;
    assign data0_out     = data0_q;
    assign data1_out     = data1_q;

endmodule

// File: tb/tb_dm_abstract_ctl.sv
// Directed bench for dm_abstract_ctl with a per-cycle behavioural model.
module tb_dm_abstract_ctl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ndmreset, halt_req, resume_req, exec;
    logic [31:0] command, data0_out, data1_out;
    logic [31:0] data0_in = '0, data1_in = '0;
    logic        halted = 0, done = 0, write = 0, bus = 0, haltresume = 0, exception = 0;
    int          n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    dm_abstract_ctl_if #(.ABITS(7)) dmi ();

    dm_abstract_ctl #(.ABITS(7), .DATACOUNT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dmi        (dmi),
        .ndmreset   (ndmreset),
        .halt_req   (halt_req),
        .resume_req (resume_req),
        .command    (command),
        .exec       (exec),
        .data0_out  (data0_out),
        .data1_out  (data1_out),
        .data0_in   (data0_in),
        .data1_in   (data1_in),
        .halted     (halted),
        .done       (done),
        .write      (write),
        .bus        (bus),
        .haltresume (haltresume),
        .exception  (exception)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic        m_active, m_haltreq, m_ndmreset, m_havereset, m_resuming, m_resumeack;
    logic [31:0] m_data [2];
    logic [31:0] m_cmd, m_rdata;
    logic [1:0]  m_auto;
    logic [2:0]  m_err;
    int          m_phase;   // 0 idle, 1 checking, 2 executing
    logic        m_ack;

    task automatic model_clear();
        m_haltreq = 0; m_ndmreset = 0; m_havereset = 1; m_resuming = 0; m_resumeack = 0;
        m_data[0] = 0; m_data[1] = 0; m_cmd = 0; m_auto = 0; m_err = 0; m_phase = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [6:0] a);
        case (a)
            7'h04: return m_data[0];
            7'h05: return m_data[1];
            7'h10: return {m_haltreq, 29'd0, m_ndmreset, m_active};
            7'h11: return 32'h82 | (halted ? 32'h300 : 32'hC00) |
                          (m_resumeack ? 32'h30000 : 32'h0) | (m_havereset ? 32'hC0000 : 32'h0);
            7'h16: return 32'd2 | (32'(m_err) << 8) | ((m_phase != 0) ? 32'h1000 : 32'h0);
            7'h18: return {30'd0, m_auto};
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs present this cycle.
    task automatic model_step();
        logic [6:0]  a;
        logic [31:0] wd;
        logic        rq, we, busy, ctl_wr, data_acc, start, act_n, ndm0;
        logic [2:0]  e0;
        logic [7:0]  t;
        int          idx, p0;
        rq = dmi.dmi_req; we = dmi.dmi_we; a = dmi.dmi_addr; wd = dmi.dmi_wdata;
        busy = (m_phase != 0); e0 = m_err; p0 = m_phase; ndm0 = m_ndmreset;
        ctl_wr = rq && we && a == 7'h10;
        data_acc = rq && (a == 7'h04 || a == 7'h05);
        idx = (a == 7'h05) ? 1 : 0;
        start = 0;
        m_rdata = (rq && !we) ? model_read(a) : 32'h0;
        m_ack = rq;
        act_n = ctl_wr ? wd[0] : m_active;
        if (busy && ((rq && we && (a == 7'h16 || a == 7'h17 || a == 7'h18)) || data_acc)) begin
            if (e0 == 0) m_err = 1;
        end else begin
            if (rq && we && (a == 7'h04 || a == 7'h05)) m_data[idx] = wd;
            if (data_acc && m_auto[idx] && e0 == 0) start = 1;
            if (rq && we && a == 7'h17 && e0 == 0) begin m_cmd = wd; start = 1; end
            if (rq && we && a == 7'h16) m_err = m_err & ~wd[10:8];
            if (rq && we && a == 7'h18) m_auto = wd[1:0];
        end
        if (busy && write) begin m_data[0] = data0_in; m_data[1] = data1_in; end
        if (ctl_wr) begin
            m_haltreq = wd[31]; m_ndmreset = wd[1];
            if (wd[28]) m_havereset = 0;
        end
        if (m_resuming && !halted) begin m_resuming = 0; m_resumeack = 1; end
        if (ctl_wr && wd[30] && !wd[31] && !busy) begin m_resuming = 1; m_resumeack = 0; end
        if (ndm0 || (ctl_wr && wd[1])) m_havereset = 1;
        t = m_cmd[31:24];
        case (p0)
            0: if (start) m_phase = 1;
            1: begin
                m_phase = 0;
                if (t > 2) m_err = 2;
                else if ((t == 1) ? halted : !halted) m_err = 4;
                else m_phase = 2;
            end
            default: if (done) begin
                m_phase = 0;
                if (haltresume) m_err = 4;
                else if (bus) m_err = 5;
                else if (exception) m_err = 3;
            end
        endcase
        m_active = act_n;
        if (!act_n) model_clear();
    endtask

    // Per-cycle compare against the model, sampled mid-cycle
    always @(negedge clk) begin
        logic exp_exec;
        if (!rst_n) begin
            model_clear(); m_active = 0; m_ack = 0; m_rdata = 0;
        end
        exp_exec = (m_phase == 2) && !(dmi.dmi_req && dmi.dmi_we && dmi.dmi_addr == 7'h10 &&
                                       !dmi.dmi_wdata[0]);
        check("exec", {31'd0, exec}, {31'd0, exp_exec});
        check("halt_req", {31'd0, halt_req}, {31'd0, m_haltreq & m_active});
        check("resume_req", {31'd0, resume_req}, {31'd0, m_resuming});
        check("ndmreset", {31'd0, ndmreset}, {31'd0, m_ndmreset});
        check("command", command, m_cmd);
        check("data0_out", data0_out, m_data[0]);
        check("data1_out", data1_out, m_data[1]);
        check("dmi_ack", {31'd0, dmi.dmi_ack}, {31'd0, m_ack});
        check("dmi_rdata", dmi.dmi_rdata, m_rdata);
        if (rst_n) model_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dmi_write(input logic [6:0] a, input logic [31:0] d);
        dmi.dmi_req = 1; dmi.dmi_we = 1; dmi.dmi_addr = a; dmi.dmi_wdata = d;
        tick(1);
        dmi.dmi_req = 0; dmi.dmi_we = 0; dmi.dmi_addr = 0; dmi.dmi_wdata = 0;
    endtask

    task automatic dmi_read(input logic [6:0] a, input logic [31:0] exp, input string name);
        dmi.dmi_req = 1; dmi.dmi_we = 0; dmi.dmi_addr = a;
        tick(1);
        dmi.dmi_req = 0; dmi.dmi_addr = 0;
        check(name, dmi.dmi_rdata, exp);
    endtask

    task automatic core_done(input logic w, input logic hr, input logic b, input logic e);
        done = 1; write = w; haltresume = hr; bus = b; exception = e;
        tick(1);
        done = 0; write = 0; haltresume = 0; bus = 0; exception = 0;
    endtask

    initial begin
        dmi.dmi_req = 0; dmi.dmi_we = 0; dmi.dmi_addr = 0; dmi.dmi_wdata = 0;
        tick(3);
        check("reset exec", {31'd0, exec}, 32'd0);
        check("reset halt_req", {31'd0, halt_req}, 32'd0);
        check("reset ack", {31'd0, dmi.dmi_ack}, 32'd0);
        rst_n = 1;
        tick(1);
        dmi_read(7'h11, 32'h000C0C82, "dmstatus after reset");

        // Halt, then resume
        dmi_write(7'h10, 32'h80000001);
        check("halt_req set", {31'd0, halt_req}, 32'd1);
        tick(3);
        halted = 1;
        tick(1);
        dmi_read(7'h11, 32'h000C0382, "dmstatus halted");
        dmi_write(7'h10, 32'h40000001);
        check("resume_req set", {31'd0, resume_req}, 32'd1);
        tick(2);
        check("resume_req held", {31'd0, resume_req}, 32'd1);
        halted = 0;
        tick(2);
        check("resume_req dropped", {31'd0, resume_req}, 32'd0);
        dmi_read(7'h11, 32'h000F0C82, "dmstatus resumeack");
        dmi_write(7'h10, 32'h10000001);
        dmi_read(7'h11, 32'h00030C82, "dmstatus havereset acked");

        // Access-register on a halted core with a data0/data1 result
        dmi_write(7'h10, 32'h80000001);
        halted = 1;
        dmi_write(7'h17, 32'h00221000);
        tick(1);
        check("exec asserted", {31'd0, exec}, 32'd1);
        data0_in = 32'hDEADBEEF; data1_in = 32'h12345678;
        core_done(1, 0, 0, 0);
        dmi_read(7'h16, 32'h00000002, "abstractcs idle");
        dmi_read(7'h04, 32'hDEADBEEF, "data0 result");
        dmi_read(7'h05, 32'h12345678, "data1 result");

        // Busy error, ignored command while cmderr set, then unsupported type
        dmi_write(7'h17, 32'h00221000);
        tick(1);
        dmi_write(7'h17, 32'h00221000);
        core_done(0, 0, 0, 0);
        dmi_read(7'h16, 32'h00000102, "cmderr busy");
        dmi_write(7'h17, 32'h01000000);
        tick(2);
        check("ignored command", command, 32'h00221000);
        dmi_write(7'h16, 32'h00000700);
        dmi_read(7'h16, 32'h00000002, "cmderr cleared");
        dmi_write(7'h17, 32'h05000000);
        tick(2);
        dmi_read(7'h16, 32'h00000202, "cmderr not supported");
        dmi_write(7'h16, 32'h00000700);

        // Halt/resume mismatch and completion errors
        halted = 0;
        dmi_write(7'h17, 32'h00221000);
        tick(2);
        dmi_read(7'h16, 32'h00000402, "cmderr running core");
        dmi_write(7'h16, 32'h00000700);
        halted = 1;
        dmi_write(7'h17, 32'h00221000);
        tick(1);
        core_done(0, 0, 1, 1);
        dmi_read(7'h16, 32'h00000502, "cmderr bus");
        dmi_write(7'h16, 32'h00000700);
        dmi_write(7'h17, 32'h00221000);
        tick(1);
        core_done(0, 1, 1, 0);
        dmi_read(7'h16, 32'h00000402, "cmderr haltresume");
        dmi_write(7'h16, 32'h00000700);
        dmi_write(7'h17, 32'h01000000);
        tick(2);
        dmi_read(7'h16, 32'h00000402, "cmderr quick halted");
        dmi_write(7'h16, 32'h00000700);
        dmi_write(7'h17, 32'h02000000);
        tick(1);
        check("exec access-memory", {31'd0, exec}, 32'd1);
        core_done(0, 0, 0, 1);
        dmi_read(7'h16, 32'h00000302, "cmderr exception");
        dmi_write(7'h16, 32'h00000700);

        // Autoexec from a data0 read, then kill it with dmactive=0
        dmi_write(7'h18, 32'hFFFFFFFD);
        dmi_read(7'h18, 32'h00000001, "abstractauto");
        dmi_read(7'h04, 32'hDEADBEEF, "data0 autoexec read");
        tick(1);
        check("autoexec exec", {31'd0, exec}, 32'd1);
        dmi.dmi_req = 1; dmi.dmi_we = 1; dmi.dmi_addr = 7'h10; dmi.dmi_wdata = 32'h0;
        #1;
        check("exec drop same cycle", {31'd0, exec}, 32'd0);
        @(posedge clk); #1;
        dmi.dmi_req = 0; dmi.dmi_we = 0; dmi.dmi_addr = 0;
        check("data0 cleared", data0_out, 32'h0);
        core_done(0, 1, 1, 1);
        dmi_read(7'h16, 32'h00000002, "abstractcs after deactivate");
        dmi_read(7'h11, 32'h000C0382, "dmstatus after deactivate");

        // done coinciding with a data access counts as busy
        dmi_write(7'h10, 32'h80000001);
        dmi_write(7'h17, 32'h00221000);
        tick(1);
        dmi.dmi_req = 1; dmi.dmi_we = 0; dmi.dmi_addr = 7'h05; done = 1;
        tick(1);
        dmi.dmi_req = 0; dmi.dmi_addr = 0; done = 0;
        dmi_read(7'h16, 32'h00000102, "done with data access");
        dmi_read(7'h7F, 32'h00000000, "unmapped read");
        dmi_read(7'h17, 32'h00000000, "command read");
        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
